// File: rtl/gauss_blur_3x3_if.sv
// Pixel stream bundle for the 3x3 Gaussian smoothing stage: raster input with
// start-of-frame marker, smoothed output with frame markers, valid/ready both ways.
interface gauss_blur_3x3_if;
  logic [7:0] in_pixel;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_sof;
  logic       out_eof;
  logic       out_ready;

  modport slave (
    input  in_pixel, in_valid, in_sof, out_ready,
    output in_ready, out_pixel, out_valid, out_sof, out_eof
  );

  modport master (
    output in_pixel, in_valid, in_sof, out_ready,
    input  in_ready, out_pixel, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/gauss_blur_3x3.sv
// Streaming 3x3 Gaussian blur, [1 2 1; 2 4 2; 1 2 1] / 16 with rounding, two line
// buffers, interior pixels only, two-stage pipeline stalled by a single global enable.
module gauss_blur_3x3 #(
  parameter int unsigned COL = 800,
  parameter int unsigned ROW = 600
) (
  input logic                clock,
  input logic                reset_n,
  gauss_blur_3x3_if.slave    bus
);

  localparam int unsigned CW = $clog2(COL);
  localparam int unsigned RW = $clog2(ROW);
  localparam logic [CW-1:0] ColLast = CW'(COL - 1);
  localparam logic [RW-1:0] RowLast = RW'(ROW - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          en, accept;
  logic          produce, first_out, last_out;

  logic [7:0]    lb0 [COL];
  logic [7:0]    lb1 [COL];
  logic [7:0]    lb0_rd, lb1_rd;
  logic [7:0]    win_q [3][3];

  logic          s1_valid_q, s1_sof_q, s1_eof_q;
  logic          out_valid_q, out_sof_q, out_eof_q;
  logic [7:0]    out_pixel_q;
  logic [11:0]   sum, rnd;

  // Everything advances together; a stalled output freezes the whole stage.
  assign en           = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & en;
  assign bus.in_ready = en;

  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;

  // A start-of-frame pixel is always (0,0), whatever the counters say.
  always_comb begin
    cur_col = bus.in_sof ? '0 : col_q;
    cur_row = bus.in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  assign produce   = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign first_out = (cur_row == RW'(2)) && (cur_col == CW'(2));
  assign last_out  = (cur_row == RowLast) && (cur_col == ColLast);

  assign lb0_rd = lb0[cur_col];
  assign lb1_rd = lb1[cur_col];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers and window hold data only; validity lives in the tags below.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb1[cur_col] <= lb0_rd;
      lb0[cur_col] <= bus.in_pixel;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_rd;
      win_q[1][2] <= lb0_rd;
      win_q[2][2] <= bus.in_pixel;
    end
  end

  always_comb begin
    sum = 12'(win_q[0][0]) + 12'(win_q[0][2]) + 12'(win_q[2][0]) + 12'(win_q[2][2])
        + (12'(win_q[0][1]) << 1) + (12'(win_q[1][0]) << 1)
        + (12'(win_q[1][2]) << 1) + (12'(win_q[2][1]) << 1)
        + (12'(win_q[1][1]) << 2);
    rnd = sum + 12'd8;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_pixel_q <= '0;
    end else if (en) begin
      s1_valid_q  <= accept & produce;
      s1_sof_q    <= accept & first_out;
      s1_eof_q    <= accept & last_out;
      out_valid_q <= s1_valid_q;
      out_sof_q   <= s1_valid_q & s1_sof_q;
      out_eof_q   <= s1_valid_q & s1_eof_q;
      if (s1_valid_q) begin
        out_pixel_q <= rnd[11:4];
      end
    end
  end

endmodule

// File: tb/tb_gauss_blur_3x3.sv
// Bench for gauss_blur_3x3 on a 5x4 frame: a direct-convolution reference model,
// a per-cycle output checker, and literal expectations for the directed images.
module tb_gauss_blur_3x3;

  localparam int COLS = 5;
  localparam int ROWS = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  gauss_blur_3x3_if bus();

  gauss_blur_3x3 #(.COL(COLS), .ROW(ROWS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int img [ROWS][COLS];
  int m_col = 0;
  int m_row = 0;
  int exp_pix[$];
  int exp_sof[$];
  int exp_eof[$];
  int exp_cyc[$];
  int got_pix[$];
  int got_sof[$];
  int got_eof[$];
  bit bp_mode = 1'b0;
  bit lat_chk = 1'b1;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain 3x3 weighted average over the stored frame.
  function automatic int model_out(input int r, input int c);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += img[r+dr][c+dc] * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
    return (s + 8) / 16;
  endfunction

  function automatic int pat(input int kind, input int r, input int c);
    case (kind)
      0: return 100;
      1: return (r == 1 && c == 1) ? 255 : 0;
      2: return 200;
      default: return 10 * c + 20 * r;
    endcase
  endfunction

  task automatic send(input int pix, input bit sof, input int gap);
    int guard = 0;
    repeat (gap) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'(pix);
    bus.in_sof   = sof;
    #1;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clock);
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      chk("accept_timeout", 0, 1);
      return;
    end
    // Accepted at the coming rising edge.
    if (sof) begin
      m_col = 0;
      m_row = 0;
    end
    img[m_row][m_col] = pix;
    if (m_row >= 2 && m_col >= 2) begin
      exp_pix.push_back(model_out(m_row - 1, m_col - 1));
      exp_sof.push_back((m_row == 2 && m_col == 2) ? 1 : 0);
      exp_eof.push_back((m_row == ROWS - 1 && m_col == COLS - 1) ? 1 : 0);
      exp_cyc.push_back(cyc + 2);
    end
    if (m_col == COLS - 1) begin
      m_col = 0;
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
    end
  endtask

  task automatic send_frame(input int kind, input int gapmax);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        send(pat(kind, r, c), (r == 0 && c == 0), gapmax > 0 ? $urandom_range(0, gapmax) : 0);
    idle(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_pix.size() != 0 || bus.out_valid); i++) @(negedge clock);
    #3;
    chk("drain_pending", exp_pix.size(), 0);
  endtask

  task automatic clear_got();
    got_pix.delete();
    got_sof.delete();
    got_eof.delete();
  endtask

  task automatic frame_shape(input string tag);
    int nsof = 0;
    int neof = 0;
    chk({tag, "_count"}, got_pix.size(), 6);
    foreach (got_sof[i]) begin
      nsof += got_sof[i];
      neof += got_eof[i];
    end
    chk({tag, "_sof_count"}, nsof, 1);
    chk({tag, "_eof_count"}, neof, 1);
    if (got_pix.size() == 6) begin
      chk({tag, "_sof_first"}, got_sof[0], 1);
      chk({tag, "_eof_last"}, got_eof[5], 1);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clock);
      bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output checker: every sample sits 2 time units after the falling edge.
  initial begin
    bit prev_stall = 1'b0;
    int prev_word = 0;
    int word;
    forever begin
      @(negedge clock);
      #2;
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      word = {21'd0, bus.out_valid, bus.out_pixel, bus.out_sof, bus.out_eof};
      if (prev_stall) chk("stall_hold", word, prev_word);
      if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", 32'(bus.in_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_pix.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("pixel", 32'(bus.out_pixel), exp_pix[0]);
          chk("sof_eof", {bus.out_sof, bus.out_eof}, exp_sof[0] * 2 + exp_eof[0]);
          if (lat_chk) chk("latency_cycle", cyc, exp_cyc[0]);
          void'(exp_pix.pop_front());
          void'(exp_sof.pop_front());
          void'(exp_eof.pop_front());
          void'(exp_cyc.pop_front());
        end
        got_pix.push_back(32'(bus.out_pixel));
        got_sof.push_back(32'(bus.out_sof));
        got_eof.push_back(32'(bus.out_eof));
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_word  = word;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got %0d expected 0 remaining", exp_pix.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int imp [6] = '{64, 32, 0, 32, 16, 0};
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.in_sof   = 1'b0;
    reset_n      = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_pixel", 32'(bus.out_pixel), 0);
    chk("reset_out_sof_eof", {bus.out_sof, bus.out_eof}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 1);

    // Flat field.
    clear_got();
    send_frame(0, 0);
    drain();
    frame_shape("flat");
    foreach (got_pix[i]) chk("flat_value", got_pix[i], 100);

    // Impulse.
    clear_got();
    send_frame(1, 0);
    drain();
    frame_shape("impulse");
    if (got_pix.size() == 6) foreach (imp[i]) chk("impulse_value", got_pix[i], imp[i]);

    // Backpressure.
    clear_got();
    bp_mode = 1'b1;
    lat_chk = 1'b0;
    send_frame(2, 0);
    drain();
    bp_mode = 1'b0;
    idle(2);
    frame_shape("backpressure");
    foreach (got_pix[i]) chk("bp_value", got_pix[i], 200);

    // Gapped ramp.
    lat_chk = 1'b1;
    clear_got();
    send_frame(3, 2);
    drain();
    frame_shape("ramp");
    if (got_pix.size() == 6) begin
      chk("ramp_first", got_pix[0], 30);
      chk("ramp_last", got_pix[5], 70);
    end

    // Asynchronous reset while an output is being presented.
    clear_got();
    for (int i = 0; i < 14; i++) send(pat(3, i / COLS, i % COLS), i == 0, 0);
    idle(1);
    for (int i = 0; i < 10 && !bus.out_valid; i++) @(negedge clock);
    #3;
    chk("pre_reset_valid", 32'(bus.out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(bus.out_valid), 0);
    chk("async_reset_pixel", 32'(bus.out_pixel), 0);
    exp_pix.delete();
    exp_sof.delete();
    exp_eof.delete();
    exp_cyc.delete();
    m_col = 0;
    m_row = 0;
    idle(3);
    reset_n = 1'b1;
    clear_got();
    @(negedge clock);
    #1;
    chk("ready_after_midframe_reset", 32'(bus.in_ready), 1);
    send_frame(3, 0);
    drain();
    frame_shape("post_reset");
    if (got_pix.size() == 6) chk("post_reset_first", got_pix[0], 30);

    // Resync: frame aborted by in_sof on its 7th pixel.
    clear_got();
    for (int i = 0; i < 6; i++) send(pat(3, i / COLS, i % COLS), i == 0, 0);
    send_frame(1, 0);
    drain();
    frame_shape("resync");
    if (got_pix.size() == 6) chk("resync_first", got_pix[0], 64);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
